// File: rtl/jtag_tap_responder.sv
// IEEE 1149.1 TAP target oversampled on clk_i: 16-state TAP FSM with IDCODE,
// BYPASS and a 32-bit USER data register bridged to a write/capture strobe port.
module jtag_tap_responder #(
  parameter int unsigned          IR_WIDTH   = 5,
  parameter logic [31:0]          IDCODE_VAL = 32'h249511C3,
  parameter logic [IR_WIDTH-1:0]  IDCODE_IR  = 5'h01,
  parameter logic [IR_WIDTH-1:0]  USER_IR    = 5'h04
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        jtag_tck_i,
  input  logic        jtag_trst_ni,
  input  logic        jtag_tms_i,
  input  logic        jtag_tdi_i,
  output logic        jtag_tdo_o,
  output logic        jtag_tdo_oe_o,
  input  logic [31:0] user_rdata_i,
  output logic        user_capture_o,
  output logic [31:0] user_wdata_o,
  output logic        user_wvalid_o,
  output logic [3:0]  tap_state_o
);

  // Encoding is visible on tap_state_o: TLR=0, RTI=1 ... UPD_IR=15.
  typedef enum logic [3:0] {
    TLR    = 4'd0,  RTI    = 4'd1,  SEL_DR = 4'd2,  CAP_DR = 4'd3,
    SH_DR  = 4'd4,  EX1_DR = 4'd5,  PAU_DR = 4'd6,  EX2_DR = 4'd7,
    UPD_DR = 4'd8,  SEL_IR = 4'd9,  CAP_IR = 4'd10, SH_IR  = 4'd11,
    EX1_IR = 4'd12, PAU_IR = 4'd13, EX2_IR = 4'd14, UPD_IR = 4'd15
  } tap_state_e;

  localparam logic [IR_WIDTH-1:0] IR_CAPTURE = IR_WIDTH'(5'b00101);

  tap_state_e          state;
  tap_state_e          next_state;
  logic [IR_WIDTH-1:0] ir;
  logic [IR_WIDTH-1:0] ir_shift;
  logic [31:0]         dr_shift;

  logic tck_s1, tck_s2, tck_s3;
  logic tms_s1, tms_s2;
  logic tdi_s1, tdi_s2;
  logic trst_s1, trst_s2;

  logic tck_rise, tck_fall;
  logic sel_idcode, sel_user;

  assign tck_rise    = tck_s2 & ~tck_s3;
  assign tck_fall    = ~tck_s2 & tck_s3;
  assign sel_idcode  = (ir == IDCODE_IR);
  assign sel_user    = (ir == USER_IR);
  assign tap_state_o = state;

  always_comb begin
    next_state = TLR;
    case (state)
      TLR:    next_state = tms_s2 ? TLR    : RTI;
      RTI:    next_state = tms_s2 ? SEL_DR : RTI;
      SEL_DR: next_state = tms_s2 ? SEL_IR : CAP_DR;
      CAP_DR: next_state = tms_s2 ? EX1_DR : SH_DR;
      SH_DR:  next_state = tms_s2 ? EX1_DR : SH_DR;
      EX1_DR: next_state = tms_s2 ? UPD_DR : PAU_DR;
      PAU_DR: next_state = tms_s2 ? EX2_DR : PAU_DR;
      EX2_DR: next_state = tms_s2 ? UPD_DR : SH_DR;
      UPD_DR: next_state = tms_s2 ? SEL_DR : RTI;
      SEL_IR: next_state = tms_s2 ? TLR    : CAP_IR;
      CAP_IR: next_state = tms_s2 ? EX1_IR : SH_IR;
      SH_IR:  next_state = tms_s2 ? EX1_IR : SH_IR;
      EX1_IR: next_state = tms_s2 ? UPD_IR : PAU_IR;
      PAU_IR: next_state = tms_s2 ? EX2_IR : PAU_IR;
      EX2_IR: next_state = tms_s2 ? UPD_IR : SH_IR;
      UPD_IR: next_state = tms_s2 ? SEL_DR : RTI;
      default: next_state = TLR;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tck_s1 <= 1'b0; tck_s2 <= 1'b0; tck_s3 <= 1'b0;
      tms_s1 <= 1'b0; tms_s2 <= 1'b0;
      tdi_s1 <= 1'b0; tdi_s2 <= 1'b0;
      trst_s1 <= 1'b1; trst_s2 <= 1'b1;
      state          <= TLR;
      ir             <= IDCODE_IR;
      ir_shift       <= '0;
      dr_shift       <= '0;
      jtag_tdo_o     <= 1'b0;
      jtag_tdo_oe_o  <= 1'b0;
      user_wdata_o   <= '0;
      user_capture_o <= 1'b0;
      user_wvalid_o  <= 1'b0;
    end else begin
      tck_s1 <= jtag_tck_i;   tck_s2 <= tck_s1; tck_s3 <= tck_s2;
      tms_s1 <= jtag_tms_i;   tms_s2 <= tms_s1;
      tdi_s1 <= jtag_tdi_i;   tdi_s2 <= tdi_s1;
      trst_s1 <= jtag_trst_ni; trst_s2 <= trst_s1;
      user_capture_o <= 1'b0;
      user_wvalid_o  <= 1'b0;

      if (!trst_s2) begin
        // TAP reset aborts any scan in flight; user_wdata_o is left alone.
        state         <= TLR;
        ir            <= IDCODE_IR;
        jtag_tdo_o    <= 1'b0;
        jtag_tdo_oe_o <= 1'b0;
      end else if (tck_rise) begin
        state <= next_state;
        if (next_state == TLR) ir <= IDCODE_IR;
        case (state)
          CAP_IR: ir_shift <= IR_CAPTURE;
          SH_IR:  ir_shift <= {tdi_s2, ir_shift[IR_WIDTH-1:1]};
          CAP_DR: begin
            if (sel_idcode) begin
              dr_shift <= IDCODE_VAL;
            end else if (sel_user) begin
              dr_shift       <= user_rdata_i;
              user_capture_o <= 1'b1;
            end else begin
              dr_shift <= '0;
            end
          end
          SH_DR: begin
            // BYPASS is a single stage: only bit 0 is live.
            if (sel_idcode || sel_user) dr_shift <= {tdi_s2, dr_shift[31:1]};
            else                        dr_shift <= {31'b0, tdi_s2};
          end
          default: ;
        endcase
      end else if (tck_fall) begin
        jtag_tdo_o    <= 1'b0;
        jtag_tdo_oe_o <= 1'b0;
        case (state)
          UPD_IR: ir <= ir_shift;
          UPD_DR: begin
            if (sel_user) begin
              user_wdata_o  <= dr_shift;
              user_wvalid_o <= 1'b1;
            end
          end
          SH_IR: begin
            jtag_tdo_o    <= ir_shift[0];
            jtag_tdo_oe_o <= 1'b1;
          end
          SH_DR: begin
            jtag_tdo_o    <= dr_shift[0];
            jtag_tdo_oe_o <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_jtag_tap_responder.sv
// Randomised scan-level bench for jtag_tap_responder: a bit-stream model of
// each IR/DR scan feeds expected TDO, capture and write queues checked by monitors.
module tb_jtag_tap_responder;

  localparam int          HALF       = 6;
  localparam logic [31:0] IDCODE_VAL = 32'h249511C3;
  localparam logic [4:0]  IDCODE_IR  = 5'h01;
  localparam logic [4:0]  USER_IR    = 5'h04;
  localparam logic [3:0]  ST_TLR     = 4'd0;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        jtag_tck = 1'b0;
  logic        jtag_trst_n = 1'b1;
  logic        jtag_tms = 1'b0;
  logic        jtag_tdi = 1'b0;
  logic        jtag_tdo;
  logic        jtag_tdo_oe;
  logic [31:0] user_rdata = '0;
  logic        user_capture;
  logic [31:0] user_wdata;
  logic        user_wvalid;
  logic [3:0]  tap_state;

  jtag_tap_responder dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .jtag_tck_i    (jtag_tck),
    .jtag_trst_ni  (jtag_trst_n),
    .jtag_tms_i    (jtag_tms),
    .jtag_tdi_i    (jtag_tdi),
    .jtag_tdo_o    (jtag_tdo),
    .jtag_tdo_oe_o (jtag_tdo_oe),
    .user_rdata_i  (user_rdata),
    .user_capture_o(user_capture),
    .user_wdata_o  (user_wdata),
    .user_wvalid_o (user_wvalid),
    .tap_state_o   (tap_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [1:0]  exp_q[$];        // {tdo_oe, tdo} per TCK period
  logic [31:0] exp_wdata_q[$];
  int          cap_q[$];        // scan id that must produce a capture pulse
  int          checks = 0;
  int          errors = 0;
  int          scan_id = 0;
  logic [4:0]  ir_model = IDCODE_IR;
  logic [31:0] wdata_model = '0;
  event        sample_ev;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h (scan %0d)", name, act, exp, scan_id);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s unexpected event (scan %0d)", name, scan_id);
  endtask

  // ---------------- monitors ----------------
  always begin
    @(sample_ev);
    if (exp_q.size() == 0) fail_now("tdo_queue_empty");
    else check("tdo_oe_tdo", {30'b0, jtag_tdo_oe, jtag_tdo}, {30'b0, exp_q.pop_front()});
  end

  always @(negedge clk) begin
    if (user_wvalid) begin
      if (exp_wdata_q.size() == 0) fail_now("wvalid");
      else check("user_wdata", user_wdata, exp_wdata_q.pop_front());
    end
    if (user_capture) begin
      if (cap_q.size() == 0) fail_now("capture");
      else check("capture_scan", scan_id, cap_q.pop_front());
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tck_cycle(input logic tms, input logic tdi, input logic [1:0] exp);
    exp_q.push_back(exp);
    jtag_tms = tms;
    jtag_tdi = tdi;
    repeat (HALF) @(negedge clk);
    jtag_tck = 1'b1;
    repeat (HALF) @(negedge clk);
    jtag_tck = 1'b0;
    repeat (HALF) @(negedge clk);
    -> sample_ev;
  endtask

  function automatic int dr_len(input logic [4:0] ir);
    return (ir == IDCODE_IR || ir == USER_IR) ? 32 : 1;
  endfunction

  // One IR or DR scan from RTI back to RTI. The model treats the register as a
  // FIFO: captured bits come out first, then the TDI bits, delayed by its length.
  task automatic scan(input bit is_ir, input logic [31:0] din, input int n,
                      input int pause_at, input int abort_at);
    bit          bits_q[$];
    int          len;
    logic [31:0] cap;
    logic [31:0] upd;
    bit          last, pz, tms;
    scan_id++;
    if (is_ir) begin
      len = 5;
      cap = 32'h5;
    end else begin
      len = dr_len(ir_model);
      cap = (ir_model == IDCODE_IR) ? IDCODE_VAL : (ir_model == USER_IR) ? user_rdata : 32'h0;
    end
    for (int k = 0; k < len; k++) bits_q.push_back(cap[k]);
    for (int k = 0; k < n; k++)   bits_q.push_back(din[k]);
    upd = '0;
    for (int k = 0; k < len; k++) upd[k] = bits_q[n+k];
    if (!is_ir && ir_model == USER_IR) cap_q.push_back(scan_id);

    tck_cycle(1'b1, 1'b0, 2'b00);
    if (is_ir) tck_cycle(1'b1, 1'b0, 2'b00);
    tck_cycle(1'b0, 1'b0, 2'b00);
    tck_cycle(1'b0, 1'b0, {1'b1, bits_q[0]});
    for (int i = 0; i < n; i++) begin
      last = (i == n-1);
      pz   = (i == pause_at) && !last;
      tms  = last || pz;
      tck_cycle(tms, din[i], tms ? 2'b00 : {1'b1, bits_q[i+1]});
      if (i == abort_at) return;
      if (pz) begin
        tck_cycle(1'b0, 1'b0, 2'b00);
        tck_cycle(1'b0, 1'b0, 2'b00);
        tck_cycle(1'b1, 1'b0, 2'b00);
        tck_cycle(1'b0, 1'b0, {1'b1, bits_q[i+1]});
      end
    end
    if (!is_ir && ir_model == USER_IR) begin
      exp_wdata_q.push_back(upd);
      wdata_model = upd;
    end
    tck_cycle(1'b1, 1'b0, 2'b00);
    tck_cycle(1'b0, 1'b0, 2'b00);
    if (is_ir) ir_model = upd[4:0];
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_state"}, {28'b0, tap_state}, {28'b0, ST_TLR});
    check({tag, "_tdo"}, {31'b0, jtag_tdo}, 32'h0);
    check({tag, "_tdo_oe"}, {31'b0, jtag_tdo_oe}, 32'h0);
    check({tag, "_wdata"}, user_wdata, wdata_model);
    check({tag, "_wvalid"}, {31'b0, user_wvalid}, 32'h0);
    check({tag, "_capture"}, {31'b0, user_capture}, 32'h0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [4:0] op;
    int         n;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_idle("reset");

    repeat (5) tck_cycle(1'b1, 1'b0, 2'b00);
    tck_cycle(1'b0, 1'b0, 2'b00);

    scan(1'b0, 32'h0, 32, -1, -1);                     // IDCODE out
    scan(1'b1, 32'h1F, 5, -1, -1);                     // BYPASS
    scan(1'b0, 32'hA5, 8, -1, -1);
    scan(1'b1, {27'b0, USER_IR}, 5, 2, -1);            // paused IR scan
    user_rdata = $urandom;
    scan(1'b0, 32'hABBAABBA, 32, -1, -1);
    scan(1'b1, {27'b0, IDCODE_IR}, 5, -1, -1);
    scan(1'b0, $urandom, 32, -1, -1);                  // no wvalid expected
    scan(1'b1, {27'b0, USER_IR}, 5, -1, -1);
    user_rdata = 32'hDEADBEEF;
    scan(1'b0, $urandom, 32, 15, -1);                  // PauDR mid-shift

    // TRST abort after 10 USER shift bits
    scan(1'b1, {27'b0, USER_IR}, 5, -1, -1);
    user_rdata = $urandom;
    scan(1'b0, $urandom, 32, -1, 9);
    jtag_trst_n = 1'b0;
    repeat (6) @(negedge clk);
    check_idle("trst");
    jtag_trst_n = 1'b1;
    ir_model = IDCODE_IR;
    repeat (4) @(negedge clk);
    tck_cycle(1'b0, 1'b0, 2'b00);
    scan(1'b0, $urandom, 32, -1, -1);

    // rst_i abort after 10 USER shift bits
    scan(1'b1, {27'b0, USER_IR}, 5, -1, -1);
    user_rdata = $urandom;
    scan(1'b0, $urandom, 32, -1, 9);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    wdata_model = '0;
    ir_model = IDCODE_IR;
    check_idle("rst_abort");
    tck_cycle(1'b0, 1'b0, 2'b00);
    scan(1'b0, $urandom, 32, -1, -1);

    // randomised instruction / DR traffic
    for (int r = 0; r < 8; r++) begin
      case ($urandom_range(0, 2))
        0:       op = USER_IR;
        1:       op = IDCODE_IR;
        default: op = 5'($urandom_range(0, 31));
      endcase
      scan(1'b1, {27'b0, op}, 5, $urandom_range(0, 5), -1);
      user_rdata = $urandom;
      n = (dr_len(ir_model) == 32 && $urandom_range(0, 1) == 1) ? 32 : $urandom_range(1, 32);
      scan(1'b0, $urandom, n, $urandom_range(0, n), -1);
    end

    repeat (20) @(negedge clk);
    check("tdo_left", exp_q.size(), 32'h0);
    check("wdata_left", exp_wdata_q.size(), 32'h0);
    check("capture_left", cap_q.size(), 32'h0);
    check("final_wdata", user_wdata, wdata_model);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/jtag_tap_responder.md
# jtag_tap_responder

Synthesizable IEEE 1149.1 TAP responder: the target end of the JTAG link that our bench-side `jtag_pkg` and `pulp_tap_pkg` tasks drive. It oversamples TCK/TMS/TDI/TRSTn on the system clock, runs the 16-state TAP FSM, and implements IDCODE, BYPASS and a 32-bit USER data register. The USER register bridges shifted words to a simple on-chip write/capture strobe interface. It sits between the chip JTAG pads and a small L2 test agent.

## Interface
- `IR_WIDTH`, 5, instruction register width.
- `IDCODE_VAL`, 32'h249511C3, value captured by IDCODE (bit0 must be 1).
- `IDCODE_IR`, 5'h01, IDCODE opcode; IR reset value.
- `USER_IR`, 5'h04, USER register opcode.
- All-ones and any other unassigned opcode select BYPASS.

Ports:
- `clk_i`  in  1  system clock; all logic on rising edge.
- `rst_i`  in  1  synchronous, active-high reset.
- `jtag_tck_i`  in  1  asynchronous TCK; oversampled.
- `jtag_trst_ni`  in  1  asynchronous TAP reset, active low; synchronized.
- `jtag_tms_i`  in  1  TMS.
- `jtag_tdi_i`  in  1  TDI.
- `jtag_tdo_o`  out  1  TDO data.
- `jtag_tdo_oe_o`  out  1  TDO drive enable; 1 only in Shift-IR/Shift-DR.
- `user_rdata_i`  in  32  word loaded into USER DR at Capture-DR.
- `user_capture_o`  out  1  one-`clk_i` pulse when USER DR captures.
- `user_wdata_o`  out  32  last updated USER word.
- `user_wvalid_o`  out  1  one-`clk_i` pulse on USER Update-DR.

## Operation
- Sync: TCK, TMS, TDI and TRSTn each pass through 2 flops. A third TCK flop detects edges. Rise = s2&~s3; fall = ~s2&s3. TMS/TDI are used from their s2 stage at the rise.
- Synced TRSTn low: force Test-Logic-Reset (TLR) and IR=`IDCODE_IR`. This overrides any edge in the same cycle.
- FSM states: TLR, RTI, SelDR, CapDR, ShDR, Ex1DR, PauDR, Ex2DR, UpdDR, SelIR, CapIR, ShIR, Ex1IR, PauIR, Ex2IR, UpdIR.
- FSM transitions follow IEEE 1149.1 on each TCK rise, using sampled TMS.
- Five rises with TMS=1 reach TLR from any state.
- Entering TLR via the FSM also resets IR to `IDCODE_IR`.
- Actions on a TCK rise, based on the current state:
  - CapIR: IR shift reg loads 5'b00101.
  - CapDR: the selected DR loads its value. IDCODE loads `IDCODE_VAL`. BYPASS loads 0. USER loads `user_rdata_i` and pulses `user_capture_o`.
  - ShIR/ShDR: shift right; TDI enters the MSB, the LSB leaves.
- Actions on a TCK fall, based on the current state:
  - UpdIR: IR latches the shift reg.
  - UpdDR with USER selected: `user_wdata_o` gets the shift reg and `user_wvalid_o` pulses.
  - ShIR/ShDR: `jtag_tdo_o` gets the shift reg LSB and `jtag_tdo_oe_o`=1.
  - Any other state: `jtag_tdo_o`=0 and `jtag_tdo_oe_o`=0.
- DR lengths: IDCODE 32, USER 32, BYPASS 1. All registers shift LSB first.
- Pause states hold shift register contents unchanged.
- Reset values (`rst_i`): FSM=TLR, IR=`IDCODE_IR`, shift regs 0, and every output 0 (`jtag_tdo_o`, `jtag_tdo_oe_o`, `user_wdata_o`, `user_capture_o`, `user_wvalid_o`).
- `rst_i` dominates TRSTn, which dominates TCK edges.
- Reset or TRST mid-shift aborts the shift. No `user_wvalid_o` is produced and `user_wdata_o` keeps its value (it is zeroed only by `rst_i`).

## Timing
- Minimum TCK high and low time: 4 `clk_i` periods each. Faster TCK is unsupported; behaviour is then undefined.
- Pin TCK rise to FSM/shift update: 3 `clk_i` cycles (2 sync + 1 register).
- Pin TCK fall to `jtag_tdo_o` valid: 3 cycles. TDO is stable well before the next TCK rise.
- `user_capture_o`: asserted in the cycle after the CapDR rise is detected, 1 cycle wide.
- `user_wvalid_o`: asserted in the cycle after the UpdDR fall is detected, 1 cycle wide. `user_wdata_o` is valid in the same cycle and holds afterwards.
- `user_rdata_i` must be stable when the CapDR rise is detected. It is sampled in that single cycle.

## Test plan
- Reset, then 5×TMS=1, then scan DR with TDI=0 for 32 bits: out `0x249511C3` LSB first; `jtag_tdo_oe_o`=1 only during the 32 shift falls.
- Shift IR with 5'h1F (BYPASS), then shift DR with 8 bits of `0xA5`: out 0 followed by `0xA5` delayed by 1 bit.
- Shift IR with any input: first 5 bits out = 1,0,1,0,0 (5'b00101 LSB first).
- IR=`USER_IR`, shift DR with `0xABBAABBA`, pass UpdDR: exactly one `user_wvalid_o` pulse with `user_wdata_o`=`0xABBAABBA`; no pulse with IR=IDCODE.
- IR=`USER_IR`, `user_rdata_i`=`0xDEADBEEF`, CapDR then 32 shifts: one `user_capture_o` pulse; TDO = `0xDEADBEEF`; PauDR mid-shift does not corrupt the data.
- TRSTn low after 10 USER shift bits: FSM in TLR, IR=`IDCODE_IR`, no `user_wvalid_o`, next DR scan returns IDCODE; repeat with `rst_i`: all outputs 0.
